// File: rtl/addsub_misr_pipe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// addsub_pkg : shared BIST state enum, default polynomials and add/sub reference
// Rev 1.0
// ----------------------------------------------------------------------------
package addsub_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_t;

  localparam logic [8:0]  c_misr_taps_default = 9'h011;
  localparam logic [16:0] c_lfsr_taps_default = 17'h12000;
  localparam logic [16:0] c_lfsr_seed_default = 17'h00001;

  // {cout,sum} of a +/- b at width+1 bits; operands wider than 'width' are masked
  function automatic logic [32:0] addsub_ref(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        sub,
                                             input int unsigned width);
    logic [32:0] mask;
    logic [32:0] sum;
    mask = (33'd1 << width) - 33'd1;
    sum  = ({1'b0, a} & mask) + ({1'b0, (sub ? ~b : b)} & mask) + {32'd0, sub};
    return sum & ((mask << 1) | 33'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_misr_pipe_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// addsub_misr_pipe_if : operand/result handshake bundle for addsub_misr_pipe
// Rev 1.0
// ----------------------------------------------------------------------------
interface addsub_misr_pipe_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   result;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, sub, in_valid, out_ready,
    input  in_ready, result, out_valid
  );

  modport slave (
    input  a, b, sub, in_valid, out_ready,
    output in_ready, result, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/addsub_misr_pipe_misr_n.sv
`default_nettype none
// ----------------------------------------------------------------------------
// misr_n : N-bit Galois MISR with synchronous clear (priority) and enable
// Rev 1.0
// ----------------------------------------------------------------------------
module misr_n #(
  parameter int           N    = 9,
  parameter logic [N-1:0] TAPS = 9'h011
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [N-1:0] data,
  output logic [N-1:0] sig
);

  logic [N-1:0] r_sig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= '0;
    end else if (clear) begin
      r_sig <= '0;
    end else if (en) begin
      r_sig <= {r_sig[N-2:0], 1'b0} ^ (r_sig[N-1] ? TAPS : '0) ^ data;
    end
  end

  assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/addsub_misr_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// addsub_misr_pipe : registered add/sub with MISR compaction; ADDSUB_BIST_EN adds
//                    an LFSR pattern source and BIST controller
// Rev 1.0
// ----------------------------------------------------------------------------
module addsub_misr_pipe
  import addsub_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH:0]   MISR_TAPS   = c_misr_taps_default,
  parameter int               PATTERN_CNT = 256,
  parameter logic [2*WIDTH:0] LFSR_SEED   = c_lfsr_seed_default,
  parameter logic [2*WIDTH:0] LFSR_TAPS   = c_lfsr_taps_default
) (
  input  logic                     clk,
  input  logic                     rst,
  addsub_misr_pipe_if.slave        bus,
  input  logic                     misr_en,
  input  logic                     misr_clear,
  output logic [WIDTH:0]           signature,
  input  logic                     bist_start,
  output logic                     bist_busy,
  output logic                     bist_done
);

  logic             w_busy;
  logic             w_run;
  logic             w_clr_st;
  logic             w_done_st;
  logic [WIDTH-1:0] w_pat_a;
  logic [WIDTH-1:0] w_pat_b;
  logic             w_pat_sub;

  logic [WIDTH:0]   r_result;
  logic             r_out_valid;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_sub;
  logic [WIDTH:0]   w_ref;
  logic             w_in_valid;
  logic             w_in_ready;
  logic             w_out_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_misr_clear;
  logic             w_misr_en;

`ifdef ADDSUB_BIST_EN
  localparam logic [16:0] c_last = 17'(PATTERN_CNT - 1);

  bist_state_t      r_state;
  logic [2*WIDTH:0] r_lfsr;
  logic [16:0]      r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             w_lfsr_fb;

  assign w_lfsr_fb = ^(r_lfsr & LFSR_TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_lfsr  <= LFSR_SEED;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bist_start) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_lfsr  <= LFSR_SEED;
          r_cnt   <= '0;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_in_ready) begin
            r_lfsr <= {r_lfsr[2*WIDTH-1:0], w_lfsr_fb};
            r_cnt  <= r_cnt + 17'd1;
            if (r_cnt == c_last) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!r_out_valid) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bist_start) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign w_busy    = r_busy;
  assign w_run     = (r_state == ST_RUN);
  assign w_clr_st  = (r_state == ST_CLEAR);
  assign w_done_st = (r_state == ST_DONE);
  assign w_pat_a   = r_lfsr[2*WIDTH:WIDTH+1];
  assign w_pat_b   = r_lfsr[WIDTH:1];
  assign w_pat_sub = r_lfsr[0];
  assign bist_busy = r_busy;
  assign bist_done = r_done;
`else
  logic w_unused;

  assign w_unused  = ^{bist_start, LFSR_SEED, LFSR_TAPS, 32'(PATTERN_CNT)};
  assign w_busy    = 1'b0;
  assign w_run     = 1'b0;
  assign w_clr_st  = 1'b0;
  assign w_done_st = 1'b0;
  assign w_pat_a   = '0;
  assign w_pat_b   = '0;
  assign w_pat_sub = 1'b0;
  assign bist_busy = 1'b0;
  assign bist_done = 1'b0;
`endif

  // While busy the external port is fenced off and results are sunk every cycle
  assign w_out_ready = w_busy | bus.out_ready;
  assign w_in_ready  = !r_out_valid || w_out_ready;
  assign w_in_valid  = w_busy ? w_run : bus.in_valid;
  assign w_in_fire   = w_in_valid && w_in_ready;
  assign w_out_fire  = r_out_valid && w_out_ready;

  assign w_a   = w_run ? w_pat_a   : bus.a;
  assign w_b   = w_run ? w_pat_b   : bus.b;
  assign w_sub = w_run ? w_pat_sub : bus.sub;
  assign w_ref = (WIDTH+1)'(addsub_ref(32'(w_a), 32'(w_b), w_sub, WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_result    <= w_ref;
      r_out_valid <= 1'b1;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = !w_busy && w_in_ready;
  assign bus.out_valid = !w_busy && r_out_valid;
  assign bus.result    = r_result;

  // A finished BIST signature stays frozen until the next run clears it
  assign w_misr_clear = w_clr_st || (!w_busy && !w_done_st && misr_clear);
  assign w_misr_en    = w_out_fire && (w_busy || (misr_en && !w_done_st));

  misr_n #(
    .N    (WIDTH + 1),
    .TAPS (MISR_TAPS)
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (w_misr_clear),
    .en    (w_misr_en),
    .data  (r_result),
    .sig   (signature)
  );

endmodule
`default_nettype wire

// File: tb/tb_addsub_misr_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_addsub_misr_pipe : directed self-checking bench with a behavioural model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_addsub_misr_pipe;
  import addsub_pkg::*;

  logic       clk;
  logic       rst;
  logic       misr_en;
  logic       misr_clear;
  logic [8:0] signature;
  logic       bist_start;
  logic       bist_busy;
  logic       bist_done;

  int checks = 0;
  int errors = 0;

  addsub_misr_pipe_if #(.WIDTH(8)) bus ();

  addsub_misr_pipe #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .misr_en    (misr_en),
    .misr_clear (misr_clear),
    .signature  (signature),
    .bist_start (bist_start),
    .bist_busy  (bist_busy),
    .bist_done  (bist_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] misr_step(input logic [8:0] s, input logic [8:0] d);
    logic [9:0] sh;
    sh = {s, 1'b0};
    return sh[8:0] ^ (s[8] ? 9'h011 : 9'h000) ^ d;
  endfunction

  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [32:0] r;
    r = addsub_ref({24'd0, a}, {24'd0, b}, s, 8);
    return r[8:0];
  endfunction

  function automatic logic [8:0] bist_golden();
    logic [16:0] l;
    logic [8:0]  s;
    l = 17'h00001;
    s = 9'h000;
    for (int i = 0; i < 256; i++) begin
      s = misr_step(s, ref8(l[16:9], l[8:1], l[0]));
      l = {l[15:0], ^(l & 17'h12000)};
    end
    return s;
  endfunction

  // Behavioural model: one output slot plus a signature, updated per handshake
  logic       mon_en;
  logic       m_valid;
  logic [8:0] m_result;
  logic [8:0] m_sig;
  logic [8:0] got[$];

  always @(negedge clk) begin
    logic o_fire;
    logic i_fire;
    if (rst) begin
      m_valid  = 1'b0;
      m_result = 9'h000;
      m_sig    = 9'h000;
    end else if (mon_en) begin
      chk("model_out_valid", bus.out_valid, m_valid);
      if (m_valid) chk("model_result", bus.result, m_result);
      chk("model_in_ready", bus.in_ready, !m_valid || bus.out_ready);
      chk("model_signature", signature, m_sig);
      o_fire = m_valid && bus.out_ready;
      i_fire = bus.in_valid && (!m_valid || bus.out_ready);
      if (misr_clear) m_sig = 9'h000;
      else if (o_fire && misr_en) m_sig = misr_step(m_sig, m_result);
      if (o_fire) got.push_back(m_result);
      if (i_fire) begin
        m_valid  = 1'b1;
        m_result = ref8(bus.a, bus.b, bus.sub);
      end else if (o_fire) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic s);
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
  endtask

  task automatic run_bist(output logic [8:0] s);
    int busy_cnt;
    int guard;
    int bad;
    @(posedge clk); #1 bist_start = 1'b1;
    @(posedge clk); #1 bist_start = 1'b0;
    drive(8'h5A, 8'hC3, 1'b0);  // external beats must be ignored while busy
    busy_cnt = 0;
    guard    = 0;
    bad      = 0;
    @(negedge clk);
    while (!bist_done && guard < 2000) begin
      if (bist_busy) busy_cnt++;
      if (bist_busy && (bus.in_ready || bus.out_valid)) bad++;
      guard++;
      @(negedge clk);
    end
    chk("bist_done", bist_done, 1);
    chk("bist_busy_cycles", busy_cnt, 259);
    chk("bist_ext_fenced", bad, 0);
    s = signature;
    bus.in_valid = 1'b0;
  endtask

  logic [7:0] vt_a  [8] = '{8'h05, 8'h03, 8'hFF, 8'h80, 8'h00, 8'h7F, 8'hAA, 8'h00};
  logic [7:0] vt_b  [8] = '{8'h03, 8'h05, 8'h01, 8'h80, 8'h01, 8'h01, 8'h55, 8'h00};
  logic       vt_s  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [8:0] vt_e  [8] = '{9'h102, 9'h0FE, 9'h100, 9'h100, 9'h0FF, 9'h080, 9'h155, 9'h100};

  logic [7:0] bp_a  [4] = '{8'h10, 8'h20, 8'h01, 8'hF0};
  logic [7:0] bp_b  [4] = '{8'h20, 8'h10, 8'h02, 8'hF0};
  logic       bp_s  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [8:0] bp_e  [4] = '{9'h030, 9'h110, 9'h0FF, 9'h1E0};

  initial begin
    int         idx;
    logic [8:0] gold;
    logic [8:0] s1;
    logic [8:0] s2;
    rst = 1'b1; mon_en = 1'b0;
    bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    misr_en = 1'b0; misr_clear = 1'b0; bist_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_result", bus.result, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_signature", signature, 0);
    chk("rst_busy", bist_busy, 0);
    chk("rst_done", bist_done, 0);
    @(posedge clk); #1 rst = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", bus.in_ready, 1);

    // MISR directed sequence
    @(posedge clk); #1 misr_clear = 1'b1;
    @(posedge clk); #1 misr_clear = 1'b0; misr_en = 1'b1; drive(8'h05, 8'h03, 1'b1);
    @(posedge clk); #1 drive(8'h03, 8'h05, 1'b1);
    @(negedge clk); chk("sub_5_3", bus.result, 9'h102); chk("sig_cleared", signature, 9'h000);
    @(posedge clk); #1 drive(8'hFF, 8'h01, 1'b0);
    @(negedge clk); chk("sub_3_5", bus.result, 9'h0FE); chk("sig_one_beat", signature, 9'h102);
    @(posedge clk); #1 bus.in_valid = 1'b0; misr_clear = 1'b1;
    @(negedge clk); chk("add_ff_1", bus.result, 9'h100); chk("sig_two_beats", signature, 9'h0EB);
    @(posedge clk); #1 misr_clear = 1'b0;
    @(negedge clk); chk("sig_clear_wins", signature, 9'h000); chk("drained", bus.out_valid, 0);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 drive(vt_a[i], vt_b[i], vt_s[i]);
      @(posedge clk); #1 bus.in_valid = 1'b0;
      @(negedge clk); chk("vec_result", bus.result, vt_e[i]);
    end

    // Backpressure: out_ready low for three cycles after the first beat
    @(posedge clk); #1 got.delete();
    idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk); #1;
      bus.out_ready = !(cyc >= 1 && cyc <= 3);
      bus.in_valid  = (idx < 4);
      if (idx < 4) begin
        bus.a = bp_a[idx]; bus.b = bp_b[idx]; bus.sub = bp_s[idx];
      end
      @(negedge clk);
      if (cyc == 2) chk("bp_in_ready_low", bus.in_ready, 0);
      if (cyc == 3) chk("bp_result_held", bus.result, bp_e[0]);
      if (bus.in_valid && bus.in_ready) idx++;
    end
    @(posedge clk); #1 bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp_beat_count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk("bp_order", got[i], bp_e[i]);
    end

`ifdef ADDSUB_BIST_EN
    gold = bist_golden();
    @(posedge clk); #1 mon_en = 1'b0; misr_en = 1'b0;
    run_bist(s1);
    chk("bist_sig_run1", s1, gold);
    run_bist(s2);
    chk("bist_sig_run2", s2, gold);

    // Reset after 100 issued vectors
    @(posedge clk); #1 bist_start = 1'b1;
    @(posedge clk); #1 bist_start = 1'b0;
    repeat (101) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_result", bus.result, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_signature", signature, 0);
    chk("midrst_busy", bist_busy, 0);
    chk("midrst_done", bist_done, 0);
    @(posedge clk); #1 rst = 1'b0;
    run_bist(s1);
    chk("bist_sig_after_rst", s1, gold);
`else
    gold = 9'h000; s1 = 9'h000; s2 = 9'h000;
    @(posedge clk); #1 bist_start = 1'b1; drive(8'h12, 8'h34, 1'b0);
    @(posedge clk); #1 bist_start = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("nobist_result", bus.result, 9'h046);
    chk("nobist_out_valid", bus.out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      chk("nobist_busy", bist_busy, 0);
      chk("nobist_done", bist_done, 0);
      @(negedge clk);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
